// File: rtl/instr_decoder.sv
// Multi-cycle control FSM for the nlp16 CPU: classifies the two-word instruction and
// sequences ADDR/MEM/EXEC micro-states. Optional macro DECODER_STRICT_EN traps nonzero ir1[11:6].
module instr_decoder (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_ir1,
    input  logic [15:0] i_ir2,
    output logic [3:0]  o_state,
    output logic        o_err,
    output logic [5:0]  o_alu_op,
    output logic [3:0]  o_s1,
    output logic [3:0]  o_s2,
    output logic [3:0]  o_dest,
    output logic        o_mem_wr,
    output logic        o_mem_rd
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'h0,
        ST_DECODE = 4'h1,
        ST_ADDR   = 4'h2,
        ST_MEM_RD = 4'h3,
        ST_MEM_WR = 4'h4,
        ST_EXEC   = 4'h5,
        ST_DONE   = 4'h6,
        ST_ERR    = 4'hF
    } state_t;

    localparam logic [3:0] MODE_NOP    = 4'h0;
    localparam logic [3:0] MODE_ALU_RR = 4'h2;
    localparam logic [3:0] MODE_ALU_RI = 4'h3;
    localparam logic [3:0] MODE_LOAD   = 4'h8;
    localparam logic [3:0] MODE_STORE  = 4'h9;
    localparam logic [3:0] MODE_LDOP   = 4'hB;

    localparam logic [3:0] REG_ZERO = 4'h0;
    localparam logic [3:0] REG_TMP  = 4'hA;
    localparam logic [3:0] REG_MDR  = 4'hB;
    localparam logic [3:0] REG_MAR  = 4'hC;
    localparam logic [3:0] REG_IMM  = 4'hD;

    localparam logic [5:0] ALU_PASS = 6'h00;
    localparam logic [5:0] ALU_ADD  = 6'h01;

    state_t state, state_nxt;

    logic [3:0] mode_p0;
    logic [5:0] op_p0;
    logic [3:0] dest_p0;
    logic [3:0] src1_p0;
    logic [3:0] src2_p0;

    logic       bad_rsvd;
    logic       unused_bits;

`ifdef DECODER_STRICT_EN
    assign bad_rsvd = |i_ir1[11:6];
`else
    assign bad_rsvd = 1'b0;
`endif

    assign unused_bits = ^{i_ir2[3:0], i_ir1[11:6]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- IR capture: on the edge leaving DECODE; outputs never read it before then
    always_ff @(posedge i_clk) begin
        if (state == ST_DECODE) begin
            mode_p0 <= i_ir1[15:12];
            op_p0   <= i_ir1[5:0];
            dest_p0 <= i_ir2[15:12];
            src1_p0 <= i_ir2[11:8];
            src2_p0 <= i_ir2[7:4];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (bad_rsvd) begin
                    state_nxt = ST_ERR;
                end else begin
                    case (i_ir1[15:12])
                        MODE_NOP:    state_nxt = ST_DONE;
                        MODE_ALU_RR: state_nxt = ST_EXEC;
                        MODE_ALU_RI: state_nxt = ST_EXEC;
                        MODE_LOAD:   state_nxt = ST_ADDR;
                        MODE_STORE:  state_nxt = ST_ADDR;
                        MODE_LDOP:   state_nxt = ST_ADDR;
                        default:     state_nxt = ST_ERR;
                    endcase
                end
            end
            ST_ADDR:   state_nxt = (mode_p0 == MODE_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: state_nxt = (mode_p0 == MODE_LDOP) ? ST_EXEC : ST_DONE;
            ST_MEM_WR: state_nxt = ST_DONE;
            ST_EXEC:   state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_DECODE;
            ST_ERR:    state_nxt = ST_ERR;
            default:   state_nxt = ST_ERR;
        endcase
    end

    // ---- Moore output decode from state and the captured IR fields
    always_comb begin
        o_alu_op = ALU_PASS;
        o_s1     = REG_ZERO;
        o_s2     = REG_ZERO;
        o_dest   = REG_ZERO;
        o_mem_rd = 1'b0;
        o_mem_wr = 1'b0;
        case (state)
            ST_ADDR: begin
                o_alu_op = ALU_ADD;
                o_s1     = src1_p0;
                o_s2     = src2_p0;
                o_dest   = REG_MAR;
            end
            ST_MEM_RD: begin
                o_mem_rd = 1'b1;
                o_s1     = REG_MDR;
                o_dest   = (mode_p0 == MODE_LDOP) ? REG_TMP : dest_p0;
            end
            ST_MEM_WR: begin
                o_mem_wr = 1'b1;
                o_s1     = dest_p0;
                o_dest   = REG_MDR;
            end
            ST_EXEC: begin
                o_alu_op = op_p0;
                o_dest   = dest_p0;
                case (mode_p0)
                    MODE_ALU_RI: begin
                        o_s1 = src1_p0;
                        o_s2 = REG_IMM;
                    end
                    MODE_LDOP: begin
                        o_s1 = REG_TMP;
                        o_s2 = src2_p0;
                    end
                    default: begin
                        o_s1 = src1_p0;
                        o_s2 = src2_p0;
                    end
                endcase
            end
            default: ;
        endcase
    end

    assign o_state = state;
    assign o_err   = (state == ST_ERR);

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: per-cycle expected output records are queued when an
// instruction is driven and compared each cycle on the falling clock edge.
module tb_instr_decoder;

    logic        i_clk;
    logic        i_rst_n;
    logic [15:0] i_ir1;
    logic [15:0] i_ir2;
    logic [3:0]  o_state;
    logic        o_err;
    logic [5:0]  o_alu_op;
    logic [3:0]  o_s1;
    logic [3:0]  o_s2;
    logic [3:0]  o_dest;
    logic        o_mem_wr;
    logic        o_mem_rd;

    int n_chk;
    int n_pass;

    logic [24:0] exp_q[$];

    instr_decoder dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_ir1    (i_ir1),
        .i_ir2    (i_ir2),
        .o_state  (o_state),
        .o_err    (o_err),
        .o_alu_op (o_alu_op),
        .o_s1     (o_s1),
        .o_s2     (o_s2),
        .o_dest   (o_dest),
        .o_mem_wr (o_mem_wr),
        .o_mem_rd (o_mem_rd)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [24:0] rec(input logic [3:0] st, input logic [5:0] alu,
                                        input logic [3:0] s1, input logic [3:0] s2,
                                        input logic [3:0] dest, input logic rd, input logic wr);
        return {st, (st == 4'hF), alu, s1, s2, dest, rd, wr};
    endfunction

    function automatic logic [24:0] obs();
        return {o_state, o_err, o_alu_op, o_s1, o_s2, o_dest, o_mem_rd, o_mem_wr};
    endfunction

    task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h (st=%h err=%b alu=%h s1=%h s2=%h d=%h rd=%b wr=%b) want %h",
                     tag, got, got[24:21], got[20], got[19:14], got[13:10], got[9:6], got[5:2],
                     got[1], got[0], want);
        end
    endtask

    // Independent reference sequence of per-cycle outputs, starting from DECODE.
    task automatic push_model(input logic [15:0] ir1, input logic [15:0] ir2, input int n_err);
        logic [3:0] mode;
        logic [5:0] op;
        logic [3:0] d, a, b;
        logic       bad;
        mode = ir1[15:12];
        op   = ir1[5:0];
        d    = ir2[15:12];
        a    = ir2[11:8];
        b    = ir2[7:4];
`ifdef DECODER_STRICT_EN
        bad = (ir1[11:6] != 6'd0);
`else
        bad = 1'b0;
`endif
        exp_q.push_back(rec(4'h1, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        if (!bad && mode == 4'h0) begin
            exp_q.push_back(rec(4'h6, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        end else if (!bad && mode == 4'h2) begin
            exp_q.push_back(rec(4'h5, op, a, b, d, 1'b0, 1'b0));
            exp_q.push_back(rec(4'h6, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        end else if (!bad && mode == 4'h3) begin
            exp_q.push_back(rec(4'h5, op, a, 4'hD, d, 1'b0, 1'b0));
            exp_q.push_back(rec(4'h6, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        end else if (!bad && mode == 4'h8) begin
            exp_q.push_back(rec(4'h2, 6'h01, a, b, 4'hC, 1'b0, 1'b0));
            exp_q.push_back(rec(4'h3, 6'h00, 4'hB, 4'h0, d, 1'b1, 1'b0));
            exp_q.push_back(rec(4'h6, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        end else if (!bad && mode == 4'h9) begin
            exp_q.push_back(rec(4'h2, 6'h01, a, b, 4'hC, 1'b0, 1'b0));
            exp_q.push_back(rec(4'h4, 6'h00, d, 4'h0, 4'hB, 1'b0, 1'b1));
            exp_q.push_back(rec(4'h6, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        end else if (!bad && mode == 4'hB) begin
            exp_q.push_back(rec(4'h2, 6'h01, a, b, 4'hC, 1'b0, 1'b0));
            exp_q.push_back(rec(4'h3, 6'h00, 4'hB, 4'h0, 4'hA, 1'b1, 1'b0));
            exp_q.push_back(rec(4'h5, op, 4'hA, b, d, 1'b0, 1'b0));
            exp_q.push_back(rec(4'h6, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        end else begin
            for (int k = 0; k < n_err; k++)
                exp_q.push_back(rec(4'hF, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        end
    endtask

    // Called on a falling edge; returns on a falling edge with the DUT in DECODE.
    task automatic reset_dut(input string tag);
        i_rst_n = 1'b0;
        #1;
        chk({tag, "_async"}, obs(), rec(4'h0, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, "_hold"}, obs(), rec(4'h0, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        i_rst_n = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Drive one instruction in DECODE and compare every following cycle. The IR inputs are
    // scrambled once the DUT has left DECODE. abort_at >= 0 fires an async reset mid-cycle.
    task automatic do_instr(input string tag, input logic [15:0] ir1, input logic [15:0] ir2,
                            input int n_err, input int abort_at);
        int idx;
        logic [24:0] e;
        i_ir1 = ir1;
        i_ir2 = ir2;
        push_model(ir1, ir2, n_err);
        idx = 0;
        while (exp_q.size() > 0) begin
            if (idx == 1) begin
                i_ir1 = 16'($urandom);
                i_ir2 = 16'($urandom);
            end
            e = exp_q.pop_front();
            chk($sformatf("%s_c%0d", tag, idx), obs(), e);
            if (idx == abort_at) begin
                exp_q.delete();
                #2;
                i_rst_n = 1'b0;
                #1;
                chk({tag, "_abort"}, obs(), rec(4'h0, 6'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
                @(posedge i_clk);
                @(negedge i_clk);
                i_rst_n = 1'b1;
                @(posedge i_clk);
                @(negedge i_clk);
                return;
            end
            @(posedge i_clk);
            @(negedge i_clk);
            idx++;
        end
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        i_rst_n = 1'b1;
        i_ir1   = 16'h2005;
        i_ir2   = 16'h6700;
        @(negedge i_clk);
        reset_dut("rst0");

        do_instr("alu_a", 16'h2005, 16'h6700, 0, -1);
        do_instr("alu_b", 16'h2005, 16'h6700, 0, -1);
        do_instr("ldop",  16'hB01D, 16'h3600, 0, -1);
        do_instr("store", 16'h9000, 16'h4120, 0, -1);
        do_instr("load",  16'h8000, 16'h5340, 0, -1);
        do_instr("nop",   16'h0000, 16'hFFFF, 0, -1);
        do_instr("alu_ri", 16'h3022, 16'h9AB0, 0, -1);
        do_instr("alu_rr", 16'h203F, 16'hE120, 0, -1);

        do_instr("abort", 16'h8000, 16'h2310, 0, 2);
        do_instr("post_abort", 16'h2001, 16'h1230, 0, -1);

        do_instr("rsvd", 16'h2045, 16'h6700, 3, -1);
`ifdef DECODER_STRICT_EN
        reset_dut("rst_rsvd");
`endif

        do_instr("err5", 16'h5000, 16'h0000, 11, -1);
        reset_dut("rst_err5");
        do_instr("errF", 16'hF000, 16'h1234, 2, -1);
        reset_dut("rst_errF");
        do_instr("final", 16'h9000, 16'h4120, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
